alu_cmd_issuer: RTL
===================

# alu_cmd_issuer

- Command-side initiator for `dual_mode_alu_top`, integrated with `clk_acc` and `clk_app` both tied to `clk`.
- Accepts ALU commands from upstream over a valid/ready channel and drives the ALU's `mode_sel`, `ALU_Sel`, `A` and `B`.
- Inserts settle cycles when the mode changes, waits the mode-dependent latency, captures `Result`, and returns it with the command tag over a valid/ready response channel.
- Exactly one command is in flight at a time.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- LAT_ACC, 1, ALU latency in accurate mode (top register only)
- LAT_APP, 2, ALU latency in approximate mode (ALU register + top register)
- SWITCH_GAP, 2, settle cycles inserted when the requested mode differs from the current `alu_mode_sel`

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  issuer can accept a command
- cmd_mode  in  1  1 = accurate, 0 = approximate
- cmd_op  in  4  ALU opcode, 0x0..0x8 legal
- cmd_a, cmd_b  in  WIDTH  operands
- cmd_tag  in  4  opaque ID, returned with the response
- rsp_valid  out  1  response present
- rsp_ready  in  1  downstream accepts the response
- rsp_data  out  WIDTH  captured ALU result
- rsp_tag  out  4  tag of the answered command
- rsp_err  out  1  illegal opcode; `rsp_data` = 0
- alu_mode_sel  out  1  to ALU `mode_sel`
- alu_sel  out  4  to ALU `ALU_Sel`
- alu_a, alu_b  out  WIDTH  to ALU `A`, `B`
- alu_result  in  WIDTH  from ALU `Result`
- busy  out  1  state ≠ IDLE
- op_count  out  16  count of completed responses

## Operation
- FSM states: IDLE, SWITCH, WAIT, RESP.
- **IDLE**
  - `cmd_ready` = 1 only in IDLE.
  - A handshake (`cmd_valid` & `cmd_ready`) latches mode, op, a, b and tag.
  - Illegal op (> 0x8): `rsp_data` ← 0, `rsp_err` ← 1, go to RESP. The ALU outputs are not updated.
  - Legal op, `cmd_mode` == `alu_mode_sel`: drive `alu_sel`, `alu_a` and `alu_b` from the handshake edge. Load cnt ← LAT+1 (LAT per mode). Go to WAIT.
  - Legal op, `cmd_mode` ≠ `alu_mode_sel`: at the handshake edge set `alu_mode_sel` ← `cmd_mode`, force `alu_sel` ← 0xF (default → result 0), load cnt ← SWITCH_GAP. Go to SWITCH.
- **SWITCH**
  - cnt decrements every cycle.
  - On the edge where cnt == 1: drive `alu_sel`, `alu_a` and `alu_b` from the latched command, load cnt ← LAT+1, go to WAIT.
- **WAIT**
  - cnt decrements every cycle.
  - On the edge where cnt == 1: `rsp_data` ← `alu_result`, `rsp_err` ← 0, `rsp_tag` ← latched tag, go to RESP.
- **RESP**
  - `rsp_valid` = 1; `rsp_data`, `rsp_tag` and `rsp_err` are held stable while `rsp_ready` = 0.
  - On `rsp_valid` & `rsp_ready`: `op_count` ← `op_count` + 1 (wraps 0xFFFF → 0x0000), go to IDLE.
- ALU drive outputs hold their last values in IDLE and RESP; they change only at the edges defined above.
- `rsp_err` responses also increment `op_count`.

## Timing
- Reset values:
  - State = IDLE.
  - `cmd_ready` = 1, `rsp_valid` = 0, `rsp_data` = 0, `rsp_tag` = 0, `rsp_err` = 0.
  - `alu_mode_sel` = 1, `alu_sel` = 0xF, `alu_a` = `alu_b` = 0.
  - `busy` = 0, `op_count` = 0.
- Handshake-to-`rsp_valid` latency, with the handshake at edge E0 and `rsp_valid` high after the edge listed:
  - Same mode: after edge E0+LAT+1. Accurate: E0+2. Approximate: E0+3.
  - Mode switch: add SWITCH_GAP. Accurate→approximate: E0+5. Approximate→accurate: E0+4.
  - Illegal op: after edge E0+1.
- Throughput with `rsp_ready` tied high: the next command handshake occurs in the first cycle after the response handshake, because IDLE re-asserts `cmd_ready`. This gives 1 op per LAT+3 cycles in steady same-mode traffic.
- `cmd_ready` is a registered state decode; it has no combinational path from `rsp_ready` or `cmd_valid`.
- Reset asserted mid-operation: immediate return to the reset values above. The in-flight command is dropped with no response, and `op_count` clears.
- `cmd_valid` high while `cmd_ready` = 0: ignored, no latching.

## Test plan
- Accurate ADD from reset (`cmd_mode`=1, op=0x0, a=5, b=7, tag=3) -> `rsp_valid` after E0+2; `rsp_data`=12, `rsp_tag`=3, `rsp_err`=0; no SWITCH state visited.
- Mode switch: approximate SUB (`cmd_mode`=0, op=0x1, a=0x100, b=0x1) issued after an accurate op -> `alu_mode_sel` drops at E0; `alu_sel`=0xF for 2 cycles, then 0x1; `rsp_valid` after E0+5; `rsp_data`=0xFF.
- Illegal op 0xA, tag=9 -> `rsp_valid` after E0+1; `rsp_err`=1, `rsp_data`=0, `rsp_tag`=9; `alu_*` outputs unchanged; `op_count` increments.
- Backpressure: accurate XOR a=0xF0F0, b=0x0FF0 with `rsp_ready`=0 for 4 cycles, plus `cmd_valid` held high with a second command -> `rsp_data`=0xFF00 stable; `cmd_ready`=0 throughout; the second command is accepted only in the cycle after `rsp_ready` rises.
- `op_count` wrap: 65536 back-to-back accurate AND ops -> `op_count` reads 0x0000 after the last response handshake; each individual result matches a & b.
- `rst` pulsed in WAIT of an approximate op -> `rsp_valid` never asserts for that command; all outputs at reset values, `alu_mode_sel`=1; the next accurate op completes normally at E0+2.

Source files
------------

// File: rtl/alu_cmd_issuer_if.sv
// Command/response channel between an upstream requester and alu_cmd_issuer.
// The requester is the master: it drives commands and accepts responses.
interface alu_cmd_issuer_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_mode;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [3:0]       cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [3:0]       rsp_tag;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_mode, cmd_op, cmd_a, cmd_b, cmd_tag,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_tag, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_op, cmd_a, cmd_b, cmd_tag,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_tag, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: single-outstanding command initiator for dual_mode_alu_top.
// Drives the ALU operands/opcode/mode, inserts settle cycles on a mode change,
// waits the mode-dependent ALU latency and returns the captured result.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | ready for a command; ALU drive outputs hold their last values
// SWITCH | mode just changed, ALU fed the default opcode while it settles
// WAIT   | ALU operands applied, counting down the result latency
// RESP   | response presented, held stable until rsp_ready
//
// SWITCH_GAP must be at least 1; LAT_ACC/LAT_APP at least 1.
module alu_cmd_issuer #(
  parameter int WIDTH      = 32,
  parameter int LAT_ACC    = 1,
  parameter int LAT_APP    = 2,
  parameter int SWITCH_GAP = 2
) (
  input  logic             clk,
  input  logic             rst,
  alu_cmd_issuer_if.slave  bus,
  output logic             alu_mode_sel_o,
  output logic [3:0]       alu_sel_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic             busy_o,
  output logic [15:0]      op_count_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SWITCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam int LAT_MAX = (LAT_ACC > LAT_APP) ? LAT_ACC : LAT_APP;
  localparam int CNT_MAX = ((LAT_MAX + 1) > SWITCH_GAP) ? (LAT_MAX + 1) : SWITCH_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LD_ACC = CNT_W'(LAT_ACC + 1);
  localparam logic [CNT_W-1:0] LD_APP = CNT_W'(LAT_APP + 1);
  localparam logic [CNT_W-1:0] LD_GAP = CNT_W'(SWITCH_GAP);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

  localparam logic [3:0] OP_MAX     = 4'h8;
  localparam logic [3:0] OP_DEFAULT = 4'hF;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // latched command
  logic             mode_q, mode_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       tag_q, tag_d;
  logic             err_q, err_d;

  // response registers
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]       rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;

  // ALU drive registers
  logic             alu_mode_q, alu_mode_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;

  logic [15:0]      op_count_q, op_count_d;

  // Next-state and datapath decode for the command/response sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    tag_d      = tag_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_err_d  = rsp_err_q;
    alu_mode_d = alu_mode_q;
    alu_sel_d  = alu_sel_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    op_count_d = op_count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          mode_d = bus.cmd_mode;
          op_d   = bus.cmd_op;
          a_d    = bus.cmd_a;
          b_d    = bus.cmd_b;
          tag_d  = bus.cmd_tag;
          if (bus.cmd_op > OP_MAX) begin
            // Illegal opcode: ALU untouched. One pass through WAIT keeps the
            // error response one cycle behind the handshake.
            err_d      = 1'b1;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            cnt_d      = CNT_1;
            state_d    = S_WAIT;
          end else if (bus.cmd_mode == alu_mode_q) begin
            err_d     = 1'b0;
            alu_sel_d = bus.cmd_op;
            alu_a_d   = bus.cmd_a;
            alu_b_d   = bus.cmd_b;
            cnt_d     = bus.cmd_mode ? LD_ACC : LD_APP;
            state_d   = S_WAIT;
          end else begin
            // Park the ALU on the default opcode while the new mode settles.
            err_d      = 1'b0;
            alu_mode_d = bus.cmd_mode;
            alu_sel_d  = OP_DEFAULT;
            cnt_d      = LD_GAP;
            state_d    = S_SWITCH;
          end
        end
      end

      S_SWITCH: begin
        cnt_d = cnt_q - CNT_1;
        if (cnt_q == CNT_1) begin
          alu_sel_d = op_q;
          alu_a_d   = a_q;
          alu_b_d   = b_q;
          cnt_d     = mode_q ? LD_ACC : LD_APP;
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - CNT_1;
        if (cnt_q == CNT_1) begin
          rsp_data_d = err_q ? '0 : alu_result_i;
          rsp_err_d  = err_q;
          rsp_tag_d  = tag_q;
          state_d    = S_RESP;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset returns to the idle/default ALU drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mode_q     <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
      alu_mode_q <= 1'b1;
      alu_sel_q  <= OP_DEFAULT;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tag_q      <= tag_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_err_q  <= rsp_err_d;
      alu_mode_q <= alu_mode_d;
      alu_sel_q  <= alu_sel_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      op_count_q <= op_count_d;
    end
  end

  // Handshake flags decode the registered state only.
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_err   = rsp_err_q;

  assign alu_mode_sel_o = alu_mode_q;
  assign alu_sel_o      = alu_sel_q;
  assign alu_a_o        = alu_a_q;
  assign alu_b_o        = alu_b_q;
  assign busy_o         = (state_q != S_IDLE);
  assign op_count_o     = op_count_q;

endmodule
